// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// cpu_types_pkg : shared CPU datapath types (fetch/decode pipeline register)
// Rev 1.0
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
  } if_id_entry_t;

  localparam word_t NOP_INSTR_DEF = '0;

endpackage
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// if_id_buffer : small in-order FIFO decoupling instruction fetch from decode
// Rev 1.0
// ============================================================================
module if_id_buffer
  import cpu_types_pkg::*;
#(
  parameter int    DEPTH     = 2,
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       enq_valid,
  input  logic [31:0]                enq_instr,
  input  logic [31:0]                enq_npc,
  output logic                       enq_ready,
  output logic                       deq_valid,
  output logic [31:0]                deq_instr,
  output logic [31:0]                deq_npc,
  input  logic                       deq_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("if_id_buffer: DEPTH must be a power of 2 and >= 2");
  end

  if_id_entry_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             enq_fire;
  logic             deq_fire;
  if_id_entry_t     head;

  // enq_ready looks only at registered occupancy, never at deq_ready.
  assign enq_ready = (count < CNT_W'(DEPTH));
  assign deq_valid = (count != '0);
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;
  assign head      = mem[rd_ptr];

  always_comb begin
    deq_instr = NOP_INSTR;
    deq_npc   = '0;
    if (deq_valid) begin
      deq_instr = head.instr;
      deq_npc   = head.npc;
    end
  end

  // Storage carries no reset; empty entries are masked by deq_valid.
  always_ff @(posedge CLK) begin
    if (enq_fire && !flush) begin
      mem[wr_ptr] <= '{instr: enq_instr, npc: enq_npc};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge CLK) disable iff (!nRST)
    count <= CNT_W'(DEPTH));
  a_no_enq_full : assert property (@(posedge CLK) disable iff (!nRST)
    enq_fire |-> (count < CNT_W'(DEPTH)));
  a_valid_count : assert property (@(posedge CLK) disable iff (!nRST)
    deq_valid == (count != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// Scoreboard bench for if_id_buffer: directed stimulus pushes expected
// {instr,npc} pairs; a negedge monitor pops and compares on every deq.
module tb_if_id_buffer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        enq_valid, deq_ready, flush;
  logic [31:0] enq_instr, enq_npc;
  logic        enq_ready, deq_valid;
  logic [31:0] deq_instr, deq_npc;
  logic [1:0]  count;

  int checks = 0;
  int passes = 0;
  logic [63:0] exp_q[$];

  if_id_buffer #(.DEPTH(2), .NOP_INSTR(32'h0)) dut (
    .CLK(CLK), .nRST(nRST),
    .enq_valid(enq_valid), .enq_instr(enq_instr), .enq_npc(enq_npc),
    .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_npc(deq_npc),
    .deq_ready(deq_ready), .flush(flush), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] n, input logic push);
    enq_valid = v;
    enq_instr = i;
    enq_npc   = n;
    if (push) exp_q.push_back({i, n});
  endtask

  // Monitor: deq fires at the coming posedge when valid & ready & !flush.
  always @(negedge CLK) begin
    if (nRST && deq_valid && deq_ready && !flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_deq", deq_instr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("deq_instr", deq_instr, e[63:32]);
        chk("deq_npc", deq_npc, e[31:0]);
      end
    end
  end

  initial begin
    nRST = 1'b1; enq_valid = 0; enq_instr = 0; enq_npc = 0; deq_ready = 0; flush = 0;
    #1 nRST = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_deq_valid", 32'(deq_valid), 0);
    chk("rst_deq_instr", deq_instr, 0);
    chk("rst_enq_ready", 32'(enq_ready), 1);
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;
    cyc();

    // Streaming: one word per cycle, occupancy steady at 1
    deq_ready = 1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h2008_0001 + 32'(i), 32'h0000_1000 + 32'(4 * i), 1);
      cyc();
      chk("stream_count", 32'(count), 1);
    end
    drive(0, 0, 0, 0);
    cyc();
    chk("stream_drain_count", 32'(count), 0);

    // Stall/full: third word refused
    deq_ready = 0;
    drive(1, 32'hA, 32'h100, 1); cyc();
    drive(1, 32'hB, 32'h104, 1); cyc();
    drive(1, 32'hC, 32'h108, 0); cyc();
    chk("full_count", 32'(count), 2);
    chk("full_enq_ready", 32'(enq_ready), 0);
    chk("full_head", deq_instr, 32'hA);
    drive(0, 0, 0, 0);
    deq_ready = 1;
    cyc(); cyc();
    chk("full_drain_count", 32'(count), 0);

    // Wrap: 3 enq (2 accepted) then 3 deq, repeated
    for (int it = 0; it < 8; it++) begin
      deq_ready = 0;
      for (int k = 0; k < 3; k++) begin
        drive(1, 32'h3000_0000 + 32'(it * 16 + k), 32'h4000_0000 + 32'(it * 64 + k * 4), k < 2);
        cyc();
      end
      drive(0, 0, 0, 0);
      deq_ready = 1;
      cyc(); cyc(); cyc();
      chk("wrap_count", 32'(count), 0);
    end

    // Flush with simultaneous enq and deq
    deq_ready = 0;
    drive(1, 32'h5555_0001, 32'h200, 0); cyc();
    drive(1, 32'h5555_0002, 32'h204, 0); cyc();
    chk("pre_flush_count", 32'(count), 2);
    drive(1, 32'hDEAD_BEEF, 32'h208, 0);
    deq_ready = 1;
    flush = 1;
    cyc();
    flush = 0;
    chk("flush_count", 32'(count), 0);
    chk("flush_deq_valid", 32'(deq_valid), 0);
    chk("flush_deq_instr", deq_instr, 0);
    drive(1, 32'h0800_0040, 32'h300, 1);
    cyc();
    chk("post_flush_valid", 32'(deq_valid), 1);
    chk("post_flush_instr", deq_instr, 32'h0800_0040);
    drive(0, 0, 0, 0);
    cyc();
    chk("post_flush_count", 32'(count), 0);

    // Full with simultaneous deq: enq refused, head popped
    deq_ready = 0;
    drive(1, 32'h6000_0001, 32'h400, 1); cyc();
    drive(1, 32'h6000_0002, 32'h404, 1); cyc();
    drive(1, 32'h6000_0003, 32'h408, 0);
    deq_ready = 1;
    cyc();
    chk("full_deq_count", 32'(count), 1);
    chk("full_deq_head", deq_instr, 32'h6000_0002);
    drive(0, 0, 0, 0);
    cyc();

    // Async reset mid-stream with 2 entries
    deq_ready = 0;
    drive(1, 32'h7000_0001, 32'h500, 0); cyc();
    drive(1, 32'h7000_0002, 32'h504, 0); cyc();
    drive(0, 0, 0, 0);
    chk("pre_rst_count", 32'(count), 2);
    #2 nRST = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_valid", 32'(deq_valid), 0);
    chk("async_rst_instr", deq_instr, 0);
    chk("async_rst_enq_ready", 32'(enq_ready), 1);
    @(posedge CLK); #3 nRST = 1'b1;
    cyc();
    deq_ready = 1;
    drive(1, 32'h1111_2222, 32'h600, 1);
    cyc();
    chk("after_rst_valid", 32'(deq_valid), 1);
    chk("after_rst_instr", deq_instr, 32'h1111_2222);
    drive(0, 0, 0, 0);
    cyc();
    chk("after_rst_count", 32'(count), 0);

    cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
